// File: rtl/if_id_fetch_stage_if.sv
// Bus between the fetch stage and its environment: instruction ROM port,
// hazard/redirect controls from ID, and the IF/ID register outputs.
interface if_id_fetch_stage_if #(
    parameter int unsigned ROM_ADDR_W = 8
);
    logic [ROM_ADDR_W-1:0] rom_addr;
    logic [31:0]           rom_data;
    logic                  stall;
    logic                  flush;
    logic                  branch_taken;
    logic [31:0]           branch_target;
    logic                  jump;
    logic [25:0]           jump_addr;
    logic                  jr;
    logic [31:0]           jr_target;
    logic [31:0]           pc_out;
    logic [31:0]           ifid_instr;
    logic [31:0]           ifid_pc_plus4;
    logic                  ifid_valid;

    modport master (
        output rom_addr, pc_out, ifid_instr, ifid_pc_plus4, ifid_valid,
        input  rom_data, stall, flush, branch_taken, branch_target,
               jump, jump_addr, jr, jr_target
    );

    modport slave (
        input  rom_addr, pc_out, ifid_instr, ifid_pc_plus4, ifid_valid,
        output rom_data, stall, flush, branch_taken, branch_target,
               jump, jump_addr, jr, jr_target
    );
endinterface

// File: rtl/if_id_fetch_stage.sv
// MIPS instruction-fetch stage with IF/ID pipeline register: PC sequencing,
// jr/jump/branch redirection (no delay slot), load-use stall and flush.
module if_id_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0040_0000,
    parameter int unsigned ROM_ADDR_W = 8,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
    input logic                  clk,
    input logic                  reset,
    if_id_fetch_stage_if.master  bus
);
    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] redirect_target;
    logic            redirect;

    logic [XLEN-1:0] ifid_instr;
    logic [XLEN-1:0] ifid_pc_plus4;
    logic            ifid_valid;
    logic [XLEN-1:0] instr_next;
    logic [XLEN-1:0] pp4_next;
    logic            valid_next;

    // Next-PC selection: stall > jr > jump > branch > sequential
    always_comb begin
        pc_plus4        = pc + XLEN'(4);
        redirect        = bus.jr | bus.jump | bus.branch_taken;
        redirect_target = pc_plus4;
        if (bus.jr) begin
            redirect_target = bus.jr_target & ALIGN_MASK;
        end else if (bus.jump) begin
            // j/jal region comes from the ID instruction's PC+4, not the fetch PC
            redirect_target = {ifid_pc_plus4[31:28], bus.jump_addr, 2'b00};
        end else if (bus.branch_taken) begin
            redirect_target = bus.branch_target & ALIGN_MASK;
        end

        pc_next = pc_plus4;
        if (bus.stall) begin
            pc_next = pc;
        end else if (redirect) begin
            pc_next = redirect_target;
        end
    end

    // IF/ID update: flush > stall > redirect bubble > load fetched word
    always_comb begin
        instr_next = bus.rom_data;
        pp4_next   = pc_plus4;
        valid_next = 1'b1;
        if (bus.flush || (!bus.stall && redirect)) begin
            instr_next = NOP_INSTR;
            pp4_next   = '0;
            valid_next = 1'b0;
        end else if (bus.stall) begin
            instr_next = ifid_instr;
            pp4_next   = ifid_pc_plus4;
            valid_next = ifid_valid;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc            <= RESET_PC;
            ifid_instr    <= NOP_INSTR;
            ifid_pc_plus4 <= '0;
            ifid_valid    <= 1'b0;
        end else begin
            pc            <= pc_next;
            ifid_instr    <= instr_next;
            ifid_pc_plus4 <= pp4_next;
            ifid_valid    <= valid_next;
        end
    end

    assign bus.rom_addr      = pc[ROM_ADDR_W+1:2];
    assign bus.pc_out        = pc;
    assign bus.ifid_instr    = ifid_instr;
    assign bus.ifid_pc_plus4 = ifid_pc_plus4;
    assign bus.ifid_valid    = ifid_valid;
endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Self-checking bench for if_id_fetch_stage: directed vector table, async
// reset sequence, then randomized traffic against a behavioural model.
module tb_if_id_fetch_stage;
    localparam logic [31:0] RESET_PC = 32'h0040_0000;
    localparam logic [31:0] NOP      = 32'h0000_0000;
    localparam int          NVEC     = 19;
    localparam int          NRAND    = 3000;

    logic clk;
    logic reset;
    logic [31:0] rom [256];

    if_id_fetch_stage_if #(.ROM_ADDR_W(8)) bus ();

    if_id_fetch_stage #(
        .RESET_PC  (RESET_PC),
        .ROM_ADDR_W(8),
        .NOP_INSTR (NOP)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    assign bus.rom_data = rom[bus.rom_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        st;
        logic        fl;
        logic        br;
        logic [31:0] bt;
        logic        jmp;
        logic [25:0] ja;
        logic        jr;
        logic [31:0] jt;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [31:0] e_pp4;
        logic        e_v;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pp4;
        logic        valid;
    } mstate_t;

    vec_t    vecs [NVEC];
    mstate_t m;

    function automatic vec_t mk(input logic st, input logic fl, input logic br,
                                input logic [31:0] bt, input logic jmp,
                                input logic [25:0] ja, input logic jr,
                                input logic [31:0] jt, input logic [31:0] e_pc,
                                input logic [31:0] e_instr, input logic [31:0] e_pp4,
                                input logic e_v);
        vec_t v;
        v.st = st; v.fl = fl; v.br = br; v.bt = bt; v.jmp = jmp; v.ja = ja;
        v.jr = jr; v.jt = jt; v.e_pc = e_pc; v.e_instr = e_instr;
        v.e_pp4 = e_pp4; v.e_v = e_v;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_pc,
                             input logic [31:0] e_instr, input logic [31:0] e_pp4,
                             input logic e_v);
        logic [7:0] e_addr;
        e_addr = 8'((e_pc >> 2) % 256);
        chk({tag, ".pc_out"},        bus.pc_out,          e_pc);
        chk({tag, ".ifid_instr"},    bus.ifid_instr,      e_instr);
        chk({tag, ".ifid_pc_plus4"}, bus.ifid_pc_plus4,   e_pp4);
        chk({tag, ".ifid_valid"},    32'(bus.ifid_valid), 32'(e_v));
        chk({tag, ".rom_addr"},      32'(bus.rom_addr),   32'(e_addr));
    endtask

    task automatic drive(input logic st, input logic fl, input logic br,
                         input logic [31:0] bt, input logic jmp, input logic [25:0] ja,
                         input logic jr, input logic [31:0] jt);
        bus.stall = st; bus.flush = fl; bus.branch_taken = br; bus.branch_target = bt;
        bus.jump = jmp; bus.jump_addr = ja; bus.jr = jr; bus.jr_target = jt;
    endtask

    // Reference: one clock edge of the fetch stage, from the behavioural rules
    function automatic mstate_t model_step(input mstate_t s, input logic st, input logic fl,
                                           input logic br, input logic [31:0] bt,
                                           input logic jmp, input logic [25:0] ja,
                                           input logic jr, input logic [31:0] jt);
        mstate_t     n;
        logic [31:0] seq;
        logic [31:0] target;
        logic        redir;
        seq    = s.pc + 32'd4;
        redir  = jr || jmp || br;
        target = jr  ? (jt - (jt % 4)) :
                 jmp ? ((s.pp4 & 32'hF000_0000) + (32'(ja) * 4)) :
                       (bt - (bt % 4));
        n.pc = st ? s.pc : (redir ? target : seq);
        if (fl || (!st && redir)) begin
            n.instr = NOP; n.pp4 = 32'd0; n.valid = 1'b0;
        end else if (st) begin
            n = '{pc: n.pc, instr: s.instr, pp4: s.pp4, valid: s.valid};
        end else begin
            n.instr = rom[(s.pc / 4) % 256]; n.pp4 = seq; n.valid = 1'b1;
        end
        return n;
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 32'h2000_0000 + 32'(i);

        vecs[0]  = mk(0,0,0,0,0,0,0,0,                       32'h0040_0004, 32'h2000_0000, 32'h0040_0004, 1);
        vecs[1]  = mk(0,0,0,0,0,0,0,0,                       32'h0040_0008, 32'h2000_0001, 32'h0040_0008, 1);
        vecs[2]  = mk(0,0,0,0,0,0,0,0,                       32'h0040_000C, 32'h2000_0002, 32'h0040_000C, 1);
        vecs[3]  = mk(1,0,0,0,0,0,0,0,                       32'h0040_000C, 32'h2000_0002, 32'h0040_000C, 1);
        vecs[4]  = mk(1,0,0,0,0,0,0,0,                       32'h0040_000C, 32'h2000_0002, 32'h0040_000C, 1);
        vecs[5]  = mk(0,0,0,0,0,0,0,0,                       32'h0040_0010, 32'h2000_0003, 32'h0040_0010, 1);
        vecs[6]  = mk(1,0,0,0,1,26'h0100040,1,32'h0040_0200, 32'h0040_0010, 32'h2000_0003, 32'h0040_0010, 1);
        vecs[7]  = mk(0,0,0,0,1,26'h0100040,0,0,             32'h0040_0100, NOP,           32'h0,         0);
        vecs[8]  = mk(0,0,0,0,0,0,0,0,                       32'h0040_0104, 32'h2000_0040, 32'h0040_0104, 1);
        vecs[9]  = mk(0,0,1,32'h0040_0103,0,0,0,0,           32'h0040_0100, NOP,           32'h0,         0);
        vecs[10] = mk(0,0,0,0,0,0,0,0,                       32'h0040_0104, 32'h2000_0040, 32'h0040_0104, 1);
        vecs[11] = mk(0,0,0,0,0,0,0,0,                       32'h0040_0108, 32'h2000_0041, 32'h0040_0108, 1);
        vecs[12] = mk(0,0,1,32'h0040_0300,1,26'h0100040,1,32'h0040_0203,
                                                             32'h0040_0200, NOP,           32'h0,         0);
        vecs[13] = mk(0,0,0,0,0,0,0,0,                       32'h0040_0204, 32'h2000_0080, 32'h0040_0204, 1);
        vecs[14] = mk(1,1,0,0,0,0,0,0,                       32'h0040_0204, NOP,           32'h0,         0);
        vecs[15] = mk(0,1,0,0,0,0,0,0,                       32'h0040_0208, NOP,           32'h0,         0);
        vecs[16] = mk(0,0,0,0,0,0,0,0,                       32'h0040_020C, 32'h2000_0082, 32'h0040_020C, 1);
        vecs[17] = mk(0,0,0,0,0,0,1,32'hFFFF_FFFF,           32'hFFFF_FFFC, NOP,           32'h0,         0);
        vecs[18] = mk(0,0,0,0,0,0,0,0,                       32'h0000_0000, 32'h2000_00FF, 32'h0000_0000, 1);

        drive(0,0,0,0,0,0,0,0);
        reset = 1'b0;
        #12;
        check_all("reset", RESET_PC, NOP, 32'h0, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].st, vecs[i].fl, vecs[i].br, vecs[i].bt,
                  vecs[i].jmp, vecs[i].ja, vecs[i].jr, vecs[i].jt);
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_instr,
                      vecs[i].e_pp4, vecs[i].e_v);
            @(negedge clk);
        end

        // Asynchronous reset between edges takes effect before the next edge
        drive(0,0,0,0,0,0,0,0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_all("async_reset", RESET_PC, NOP, 32'h0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_all("first_fetch", 32'h0040_0004, 32'h2000_0000, 32'h0040_0004, 1'b1);

        // Randomized traffic against the behavioural model
        @(negedge clk);
        for (int i = 0; i < 256; i++) rom[i] = $urandom;
        m = '{pc: 32'h0040_0004, instr: 32'h2000_0000, pp4: 32'h0040_0004, valid: 1'b1};
        for (int c = 0; c < NRAND; c++) begin
            logic st, fl, br, jmp, jr;
            logic [31:0] bt, jt;
            logic [25:0] ja;
            st  = ($urandom_range(0, 3) == 0);
            fl  = ($urandom_range(0, 9) == 0);
            br  = ($urandom_range(0, 7) == 0);
            jmp = ($urandom_range(0, 9) == 0);
            jr  = ($urandom_range(0, 11) == 0);
            bt  = $urandom;
            jt  = $urandom;
            ja  = 26'($urandom);
            drive(st, fl, br, bt, jmp, ja, jr, jt);
            m = model_step(m, st, fl, br, bt, jmp, ja, jr, jt);
            @(posedge clk);
            #1;
            check_all($sformatf("rand%0d", c), m.pc, m.instr, m.pp4, m.valid);
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/if_id_fetch_stage.md
Name: if_id_fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the MIPS pipeline.
- Holds the PC and drives the instruction-ROM word address.
- Captures the returned 32-bit instruction and PC+4 into the IF/ID register, whose instruction output feeds the ID-stage field splitter.
- Handles sequential fetch, branch/jump/jr redirection, load-use stall and IF/ID flush.

Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded on reset (text segment base).
- ROM_ADDR_W, 8, width of the instruction-ROM word address.
- NOP_INSTR, 32'h0000_0000, encoding inserted into IF/ID on flush or reset (sll $0,$0,0).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- rom_addr  output  ROM_ADDR_W  word address to instruction ROM = pc[ROM_ADDR_W+1:2].
- rom_data  input  32  instruction word from ROM; combinational (same-cycle) read.
- stall  input  1  hazard unit: hold PC and IF/ID.
- flush  input  1  clear IF/ID to bubble.
- branch_taken  input  1  ID-stage branch resolved taken.
- branch_target  input  32  branch target address.
- jump  input  1  ID-stage j/jal.
- jump_addr  input  26  instr_index field from ID.
- jr  input  1  ID-stage jr/jalr.
- jr_target  input  32  register value for jr.
- pc_out  output  32  current fetch PC.
- ifid_instr  output  32  instruction held in IF/ID; feeds the field splitter.
- ifid_pc_plus4  output  32  PC+4 of the instruction held in IF/ID.
- ifid_valid  output  1  1 = IF/ID holds a real instruction, 0 = bubble.

Behaviour:
- Reset (reset=0, asynchronous):
  - pc = RESET_PC.
  - ifid_instr = NOP_INSTR.
  - ifid_pc_plus4 = 0.
  - ifid_valid = 0.
- Release of reset is sampled synchronously; the first fetch uses RESET_PC.
- Latency: the word at pc in cycle n appears on ifid_instr after the rising edge ending cycle n (one-cycle latency).
- pc_plus4 = pc + 4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- Redirect targets, computed combinationally:
  - jump target = {ifid_pc_plus4[31:28], jump_addr, 2'b00}, using the ID-stage instruction's PC+4, not the fetch PC.
  - branch_target[1:0] and jr_target[1:0] are forced to 2'b00; no misalignment exception.
- next_pc priority, highest first:
  1. stall → pc holds.
  2. jr → jr_target.
  3. jump → jump target.
  4. branch_taken → branch_target.
  5. otherwise pc_plus4.
- No branch delay slot: any redirect (jr|jump|branch_taken with stall=0) also loads a bubble into IF/ID, discarding the wrong-path word fetched this cycle.
- IF/ID update priority, highest first:
  1. flush → NOP_INSTR, valid=0, pc_plus4=0. Applies even when stall=1.
  2. stall → hold all IF/ID contents.
  3. redirect → bubble, as for flush.
  4. otherwise ifid_instr=rom_data, ifid_pc_plus4=pc_plus4, valid=1.
- flush does not affect the PC; only stall and redirects do.
- Redirect inputs asserted while stall=1 are ignored. The ID stage keeps them asserted until the stall drops.
- Only rom_addr is combinational from pc; all other outputs are registered.

Test Plan:
- Reset then run 4 cycles with ROM[i]=32'h2000_0000+i → pc_out 0x00400000, 0x00400004, …; ifid_instr lags by one cycle; ifid_valid goes to 1 after the first edge; ifid_pc_plus4 = 0x00400004 for ROM[0].
- stall=1 for 2 cycles mid-stream → pc_out and IF/ID unchanged for exactly 2 edges, then sequential fetch resumes with no instruction lost or duplicated.
- branch_taken=1, branch_target=0x00400103 → next pc_out = 0x00400100; IF/ID becomes NOP with valid=0 for one cycle; the next IF/ID holds the word at 0x00400100.
- jump=1 with jump_addr=26'h0100040 and ifid_pc_plus4=0x00400010; jr=1 with jr_target=0x00400200 in the same cycle → pc = 0x00400200 (jr wins); without jr → pc = 0x00400100.
- flush=1 together with stall=1 → IF/ID becomes NOP with valid=0; pc holds its value.
- reset asserted mid-stream, asynchronously between edges → all outputs go to reset values immediately; pc_out = RESET_PC before the next edge.
